// File: rtl/wb_write_arbiter_if.sv
// Bus bundle for the writeback arbiter: pipeline WB slot, long-latency
// valid/ready push port, pending-register check, stall request and the
// registered register-file write port.
interface wb_write_arbiter_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic            pipe_we;
    logic [4:0]      pipe_wa;
    logic [31:0]     pipe_wd;

    logic            lng_valid;
    logic            lng_ready;
    logic [4:0]      lng_wa;
    logic [31:0]     lng_wd;

    logic [4:0]      chk_ra1;
    logic [4:0]      chk_ra2;
    logic            chk_pend1;
    logic            chk_pend2;

    logic            stall_req;
    logic [CntW-1:0] fifo_cnt;

    logic            we3;
    logic [4:0]      wa3;
    logic [31:0]     wd3;

    // Arbiter side
    modport slave (
        input  pipe_we, pipe_wa, pipe_wd,
        input  lng_valid, lng_wa, lng_wd,
        input  chk_ra1, chk_ra2,
        output lng_ready, chk_pend1, chk_pend2, stall_req, fifo_cnt,
        output we3, wa3, wd3
    );

    // Pipeline / register-file side
    modport master (
        output pipe_we, pipe_wa, pipe_wd,
        output lng_valid, lng_wa, lng_wd,
        output chk_ra1, chk_ra2,
        input  lng_ready, chk_pend1, chk_pend2, stall_req, fifo_cnt,
        input  we3, wa3, wd3
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges the non-stallable pipeline WB slot with buffered
// long-latency results onto one registered register-file write port.
// Pipeline writes always win; buffered writes drain in idle pipe slots.
// A pipeline write to register X kills any buffered write to X (younger wins).
// Optional starvation guard enabled by defining WB_STARVE_GUARD_EN; without
// it stall_req is tied low.
module wb_write_arbiter #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input logic               clk,
    input logic               rst_n,
    wb_write_arbiter_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    // FIFO state; a set live bit implies the entry is occupied
    logic [DEPTH-1:0] live_q, live_d;
    logic [4:0]       wa_q [DEPTH];
    logic [31:0]      wd_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    // Registered write port
    logic             we3_q, we3_d;
    logic [4:0]       wa3_q, wa3_d;
    logic [31:0]      wd3_q, wd3_d;

    logic pipe_busy;
    logic fifo_empty;
    logic lng_ready;
    logic pop;
    logic push;
    logic push_live;
    logic pend1, pend2;

    assign pipe_busy  = bus.pipe_we && (bus.pipe_wa != 5'd0);
    assign fifo_empty = (cnt_q == '0);
    assign lng_ready  = (cnt_q != CntFull);
    assign pop        = !pipe_busy && !fifo_empty;
    // Writes to r0 complete the handshake but are never enqueued
    assign push       = bus.lng_valid && lng_ready && (bus.lng_wa != 5'd0);
    // Same-cycle pipeline write to the same register enqueues it already dead
    assign push_live  = !(pipe_busy && (bus.pipe_wa == bus.lng_wa));

    // Next-state: output selection, kill rule, pop and push bookkeeping
    always_comb begin
        live_d   = live_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        we3_d    = 1'b0;
        wa3_d    = wa3_q;
        wd3_d    = wd3_q;

        if (pipe_busy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wa_q[i] == bus.pipe_wa) begin
                    live_d[i] = 1'b0;
                end
            end
            we3_d = 1'b1;
            wa3_d = bus.pipe_wa;
            wd3_d = bus.pipe_wd;
        end else if (pop) begin
            we3_d            = live_q[rd_ptr_q];
            wa3_d            = wa_q[rd_ptr_q];
            wd3_d            = wd_q[rd_ptr_q];
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + PtrW'(1);
        end

        if (push) begin
            live_d[wr_ptr_q] = push_live;
            wr_ptr_d         = wr_ptr_q + PtrW'(1);
        end

        cnt_d = cnt_q + CntW'(push) - CntW'(pop);
    end

    // Control state and write port registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            we3_q    <= 1'b0;
            wa3_q    <= 5'd0;
            wd3_q    <= 32'd0;
        end else begin
            live_q   <= live_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            we3_q    <= we3_d;
            wa3_q    <= wa3_d;
            wd3_q    <= wd3_d;
        end
    end

    // FIFO payload storage; contents only matter while the entry is live
    always_ff @(posedge clk) begin
        if (push) begin
            wa_q[wr_ptr_q] <= bus.lng_wa;
            wd_q[wr_ptr_q] <= bus.lng_wd;
        end
    end

    // Pending-write lookup for hazard logic; r0 is never pending
    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (wa_q[i] == bus.chk_ra1)) pend1 = 1'b1;
            if (live_q[i] && (wa_q[i] == bus.chk_ra2)) pend2 = 1'b1;
        end
        if (bus.chk_ra1 == 5'd0) pend1 = 1'b0;
        if (bus.chk_ra2 == 5'd0) pend2 = 1'b0;
    end

`ifdef WB_STARVE_GUARD_EN
    localparam int unsigned StW = $clog2(STARVE_MAX + 1);
    localparam logic [StW-1:0] StMax = StW'(STARVE_MAX);

    logic [StW-1:0] starve_q, starve_d;
    logic           stall_q, stall_d;

    // Count unserved cycles of a non-empty head; saturate at the threshold
    always_comb begin
        starve_d = starve_q;
        stall_d  = stall_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (starve_q != StMax) begin
            starve_d = starve_q + StW'(1);
        end
        if (pop) begin
            stall_d = 1'b0;
        end else if (starve_d == StMax) begin
            stall_d = 1'b1;
        end
    end

    // Starvation counter and stall request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign bus.stall_req = stall_q;
`else
    logic unused_starve_max;
    assign unused_starve_max = ^STARVE_MAX;
    assign bus.stall_req     = 1'b0;
`endif

    assign bus.lng_ready = lng_ready;
    assign bus.fifo_cnt  = cnt_q;
    assign bus.chk_pend1 = pend1;
    assign bus.chk_pend2 = pend2;
    assign bus.we3       = we3_q;
    assign bus.wa3       = wa3_q;
    assign bus.wd3       = wd3_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed scenarios plus random
// traffic; a queue-based reference model predicts each registered output and
// a monitor compares it one clock edge later.
module tb_wb_write_arbiter;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned STARVE_MAX = 8;

    logic clk = 1'b0;
    logic rst_n;

    wb_write_arbiter_if #(.DEPTH(DEPTH)) bus ();

    wb_write_arbiter #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          live;
    } ent_t;

    typedef struct {
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        int          cnt;
        bit          stall;
    } exp_t;

    ent_t        mq[$];     // model of buffered writes, head at index 0
    exp_t        eq[$];     // expected post-edge outputs
    bit          m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    int          m_wait;    // cycles the current head has gone unserved
    logic [31:0] m_rf [32];
    logic [31:0] d_rf [32]; // register file as written by the DUT port
    int          checks = 0;
    int          errors = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register file commits on the falling edge
    always @(negedge clk) begin
        if (rst_n && bus.we3) d_rf[bus.wa3] <= bus.wd3;
    end

    // Monitor: compare registered outputs just after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (eq.size() != 0) begin
                e = eq.pop_front();
                check("we3", bus.we3, e.we);
                check("wa3", bus.wa3, e.wa);
                check("wd3", bus.wd3, e.wd);
                check("fifo_cnt", bus.fifo_cnt, e.cnt);
                check("stall_req", bus.stall_req, e.stall);
            end
        end
    end

    // Drive one cycle, check combinational outputs, advance the model
    task automatic cycle(bit pwe, logic [4:0] pwa, logic [31:0] pwd,
                         bit lv, logic [4:0] lwa, logic [31:0] lwd,
                         logic [4:0] ra1, logic [4:0] ra2);
        bit   busy, rdy, pop, p1, p2;
        ent_t n;
        exp_t e;
        @(negedge clk);
        bus.pipe_we   = pwe;
        bus.pipe_wa   = pwa;
        bus.pipe_wd   = pwd;
        bus.lng_valid = lv;
        bus.lng_wa    = lwa;
        bus.lng_wd    = lwd;
        bus.chk_ra1   = ra1;
        bus.chk_ra2   = ra2;
        #1;
        busy = pwe && (pwa != 0);
        rdy  = mq.size() < DEPTH;
        p1   = 0;
        p2   = 0;
        foreach (mq[i]) begin
            if (mq[i].live && mq[i].wa == ra1 && ra1 != 0) p1 = 1;
            if (mq[i].live && mq[i].wa == ra2 && ra2 != 0) p2 = 1;
        end
        check("lng_ready", bus.lng_ready, rdy);
        check("chk_pend1", bus.chk_pend1, p1);
        check("chk_pend2", bus.chk_pend2, p2);

        pop = !busy && mq.size() != 0;
        if (pop || mq.size() == 0) m_wait = 0;
        else                       m_wait++;

        if (busy) begin
            foreach (mq[i]) if (mq[i].wa == pwa) mq[i].live = 0;
            m_we = 1;
            m_wa = pwa;
            m_wd = pwd;
        end else if (pop) begin
            n    = mq.pop_front();
            m_we = n.live;
            m_wa = n.wa;
            m_wd = n.wd;
        end else begin
            m_we = 0;
        end
        if (m_we) m_rf[m_wa] = m_wd;

        if (lv && rdy && lwa != 0) begin
            n.wa   = lwa;
            n.wd   = lwd;
            n.live = !(busy && pwa == lwa);
            mq.push_back(n);
        end

        e.we  = m_we;
        e.wa  = m_wa;
        e.wd  = m_wd;
        e.cnt = mq.size();
`ifdef WB_STARVE_GUARD_EN
        e.stall = (m_wait >= STARVE_MAX);
`else
        e.stall = 0;
`endif
        eq.push_back(e);
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_reset();
        mq.delete();
        eq.delete();
        m_we   = 0;
        m_wa   = 0;
        m_wd   = 0;
        m_wait = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_we3", bus.we3, 0);
        check("rst_wa3", bus.wa3, 0);
        check("rst_wd3", bus.wd3, 0);
        check("rst_fifo_cnt", bus.fifo_cnt, 0);
        check("rst_lng_ready", bus.lng_ready, 1);
        check("rst_stall_req", bus.stall_req, 0);
    endtask

    // Assert reset between clock edges, check asynchronous effect, release
    task automatic mid_reset();
        @(negedge clk);
        bus.pipe_we   = 0;
        bus.lng_valid = 0;
        #2;
        rst_n = 0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_rf[i] = 0;
            d_rf[i] = 0;
        end
        model_reset();
        bus.pipe_we   = 0;
        bus.pipe_wa   = 0;
        bus.pipe_wd   = 0;
        bus.lng_valid = 0;
        bus.lng_wa    = 0;
        bus.lng_wd    = 0;
        bus.chk_ra1   = 0;
        bus.chk_ra2   = 0;
        rst_n = 1;
        #2;
        rst_n = 0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        // Pipe only, then a pipe write to r0 is ignored
        cycle(1, 5, 32'h1234, 0, 0, 0, 5, 0);
        cycle(1, 0, 32'h5555, 0, 0, 0, 0, 0);
        idle(1);

        // Long-latency write drains through an idle slot
        cycle(0, 0, 0, 1, 7, 32'hDEAD, 7, 0);
        cycle(0, 0, 0, 0, 0, 0, 7, 7);
        cycle(0, 0, 0, 0, 0, 0, 7, 0);
        idle(1);

        // Fill under continuous pipe traffic, refused push, then one pop
        for (int k = 0; k < 4; k++)
            cycle(1, 5'(1 + k), $urandom, 1, 5'(10 + k), $urandom, 5'(10 + k), 11);
        cycle(1, 20, $urandom, 1, 15, 32'hBAD0, 13, 15);
        cycle(0, 0, 0, 1, 0, 32'h0, 12, 0);
        cycle(1, 21, $urandom, 0, 0, 0, 0, 0);
        idle(DEPTH + 1);

        // Kill rule: buffered r9 overtaken by a younger pipe write
        cycle(1, 3, 32'h3333, 1, 9, 32'hAAAA, 9, 0);
        cycle(1, 9, 32'hBBBB, 0, 0, 0, 9, 9);
        cycle(1, 6, 32'h6666, 1, 6, 32'hCCCC, 6, 9);
        idle(4);
        @(negedge clk);
        #1;
        check("r9_final", d_rf[9], 32'hBBBB);

        // Starvation: one queued entry while the pipe stays busy
        cycle(1, 1, $urandom, 1, 4, 32'h4444, 4, 0);
        for (int k = 0; k < STARVE_MAX + 3; k++) cycle(1, 2, $urandom, 0, 0, 0, 4, 0);
        idle(3);

        // Reset with two buffered writes discards them
        cycle(1, 1, $urandom, 1, 12, 32'h1212, 0, 0);
        cycle(1, 2, $urandom, 1, 13, 32'h1313, 0, 0);
        mid_reset();
        idle(3);

        // Random traffic: mixed load, then heavy pipe load
        for (int k = 0; k < 1500; k++) begin
            cycle($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 99) < 95, 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(DEPTH + 2);
        @(negedge clk);
        #1;
        for (int i = 1; i < 32; i++) check($sformatf("rf[%0d]", i), d_rf[i], m_rf[i]);
        check("scoreboard_drained", eq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
